// File: rtl/seq_mon_pkg.sv
// Shared definitions for the windowed match monitor: FSM encodings and
// default sizing.
package seq_mon_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ALERT = 2'd2;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_WIN_LEN = 1000;
    localparam int unsigned DEF_TMR_W   = 16;

endpackage

// File: rtl/seq_match_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the saturated
// next value and a flag for an increment attempted at full scale.
module sat_counter
    import seq_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    // sum_o ignores clr_i so the caller can capture the closing value
    // in the same cycle the counter is cleared.
    always_comb begin
        at_max  = &count_q;
        sum_o   = (inc_i && !at_max) ? count_q + CNT_W'(1) : count_q;
        ovf_o   = inc_i & at_max;
        count_d = clr_i ? '0 : sum_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_match_monitor.sv
// Counts rising edges of the detector output over fixed windows, reports
// the last window's count and raises a sticky alert on threshold.
module seq_match_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned WIN_LEN = DEF_WIN_LEN,
    parameter int unsigned TMR_W   = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             det_in,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] last_count,
    output logic             win_done,
    output logic             alert,
    output logic             sat
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             det_q;
    logic [CNT_W-1:0] last_count_q, last_count_d;
    logic             win_done_q, win_done_d;
    logic             alert_q, alert_d;
    logic             sat_q, sat_d;

    logic             match;
    logic             counting;
    logic             close;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             cnt_ovf;
    logic             over_th;
    logic [CNT_W-1:0] final_cnt;

    always_comb begin
        match    = det_in & ~det_q;
        counting = en & ((state_q == S_RUN) | (state_q == S_ALERT));
        close    = counting & ~clr & (timer_q == TMR_LAST);
        cnt_inc  = match & counting & ~clr;
        cnt_clr  = clr | ~counting | close;
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_win_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (win_count),
        .sum_o   (final_cnt),
        .ovf_o   (cnt_ovf)
    );

    always_comb begin
        over_th = (thresh != '0) && (final_cnt >= thresh);

        state_d = S_IDLE;
        if (clr) begin
            state_d = en ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = en ? S_RUN : S_IDLE;
                S_RUN: begin
                    if (!en)                   state_d = S_IDLE;
                    else if (close && over_th) state_d = S_ALERT;
                    else                       state_d = S_RUN;
                end
                S_ALERT: state_d = S_ALERT;
                default: state_d = S_IDLE;
            endcase
        end

        timer_d = '0;
        if (counting && !clr && !close) begin
            timer_d = timer_q + TMR_W'(1);
        end

        last_count_d = last_count_q;
        if (clr) begin
            last_count_d = '0;
        end else if (close) begin
            last_count_d = final_cnt;
        end

        win_done_d = close;
        alert_d    = (state_d == S_ALERT);
        sat_d      = clr ? 1'b0 : (sat_q | cnt_ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            det_q        <= 1'b0;
            last_count_q <= '0;
            win_done_q   <= 1'b0;
            alert_q      <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            det_q        <= det_in;
            last_count_q <= last_count_d;
            win_done_q   <= win_done_d;
            alert_q      <= alert_d;
            sat_q        <= sat_d;
        end
    end

    assign last_count = last_count_q;
    assign win_done   = win_done_q;
    assign alert      = alert_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Randomized and directed bench for seq_match_monitor against a
// window-level behavioural model; two instances (8- and 40-cycle windows).
module tb_seq_match_monitor;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct {
        bit running;
        bit alerting;
        bit prev;
        bit done;
        bit sat;
        int cnt;
        int last;
        int timer;
    } mdl_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       det;
    logic [3:0] thresh;

    logic [3:0] wc8, lc8, wc40, lc40;
    logic       wd8, al8, sat8, wd40, al40, sat40;

    int n_checks;
    int n_pass;

    mdl_t m8, m40;

    seq_match_monitor #(.CNT_W(CNT_W), .WIN_LEN(8), .TMR_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .det_in(det), .thresh(thresh),
        .win_count(wc8), .last_count(lc8), .win_done(wd8), .alert(al8), .sat(sat8)
    );

    seq_match_monitor #(.CNT_W(CNT_W), .WIN_LEN(40), .TMR_W(16)) u_dut40 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .det_in(det), .thresh(thresh),
        .win_count(wc40), .last_count(lc40), .win_done(wd40), .alert(al40), .sat(sat40)
    );

    always #5 clk = ~clk;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic mdl_t step(mdl_t s, int wl, bit rstn, bit e, bit c, bit d, int th);
        mdl_t n;
        bit   match;
        bit   counting;
        int   full;
        if (!rstn) return mdl_reset();
        n       = s;
        match   = d && !s.prev;
        n.prev  = d;
        n.done  = 0;
        if (c) begin
            n.cnt = 0; n.last = 0; n.timer = 0; n.sat = 0;
            n.alerting = 0; n.running = e;
            return n;
        end
        if (s.alerting) begin
            counting = e;
        end else if (s.running) begin
            counting = e; n.running = e;
        end else begin
            counting = 0; n.running = e;
        end
        if (!counting) begin
            n.cnt = 0; n.timer = 0;
        end else begin
            full = s.cnt + int'(match);
            if (full > CNT_MAX) begin
                n.sat = 1; full = CNT_MAX;
            end
            if (s.timer == wl - 1) begin
                n.last = full; n.cnt = 0; n.timer = 0; n.done = 1;
                if (th != 0 && full >= th) n.alerting = 1;
            end else begin
                n.cnt = full; n.timer = s.timer + 1;
            end
        end
        return n;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic compare_all();
        check_eq("wc8",   int'(wc8),   m8.cnt);
        check_eq("lc8",   int'(lc8),   m8.last);
        check_eq("wd8",   int'(wd8),   int'(m8.done));
        check_eq("al8",   int'(al8),   int'(m8.alerting));
        check_eq("sat8",  int'(sat8),  int'(m8.sat));
        check_eq("wc40",  int'(wc40),  m40.cnt);
        check_eq("lc40",  int'(lc40),  m40.last);
        check_eq("wd40",  int'(wd40),  int'(m40.done));
        check_eq("al40",  int'(al40),  int'(m40.alerting));
        check_eq("sat40", int'(sat40), int'(m40.sat));
    endtask

    task automatic cyc();
        @(posedge clk);
        m8  = step(m8,  8,  rst, en, clr, det, int'(thresh));
        m40 = step(m40, 40, rst, en, clr, det, int'(thresh));
        #1;
        compare_all();
    endtask

    task automatic wait_done(input int maxc, input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cyc();
            seen = wd8;
        end
        check_eq(tag, int'(seen), 1);
    endtask

    task automatic async_reset();
        #2 rst = 0;
        #1;
        m8  = mdl_reset();
        m40 = mdl_reset();
        compare_all();
        check_eq("arst_wc8", int'(wc8), 0);
        check_eq("arst_al8", int'(al8), 0);
        #1 rst = 1;
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_pass   = 0;
        clk = 0; rst = 0; en = 0; clr = 0; det = 0; thresh = 0;
        m8  = mdl_reset();
        m40 = mdl_reset();

        for (int i = 0; i < 6; i++) begin
            det = ~det;
            cyc();
        end
        check_eq("rst_wc8", int'(wc8), 0);
        check_eq("rst_lc8", int'(lc8), 0);
        check_eq("rst_sat8", int'(sat8), 0);
        det = 0;
        rst = 1;

        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            det = ~det;
            cyc();
            if (wd8) done_seen++;
        end
        check_eq("idle_done", done_seen, 0);
        check_eq("idle_wc8", int'(wc8), 0);

        det = 0; en = 1; thresh = 5;
        cyc();
        for (int i = 0; i < 3; i++) begin
            det = 1; cyc();
            det = 0; cyc();
        end
        wait_done(10, "w1_done");
        check_eq("w1_last", int'(lc8), 3);
        check_eq("w1_alert", int'(al8), 0);

        det = 1;
        repeat (5) cyc();
        det = 0;
        cyc();
        check_eq("hold_once", int'(wc8), 1);
        wait_done(10, "w2_done");
        check_eq("w2_last", int'(lc8), 1);

        thresh = 2;
        det = 1; cyc();
        det = 0; repeat (6) cyc();
        det = 1; cyc();
        check_eq("w3_done", int'(wd8), 1);
        check_eq("w3_last", int'(lc8), 2);
        check_eq("w3_alert", int'(al8), 1);
        det = 0;
        wait_done(10, "w4_done");
        check_eq("w4_last", int'(lc8), 0);
        check_eq("w4_alert", int'(al8), 1);
        clr = 1; cyc(); clr = 0;
        check_eq("clr_alert", int'(al8), 0);

        for (int i = 0; i < 17; i++) begin
            det = 1; cyc();
            det = 0; cyc();
        end
        check_eq("sat_wc40", int'(wc40), 15);
        check_eq("sat_flag40", int'(sat40), 1);
        repeat (60) cyc();
        check_eq("sat_sticky40", int'(sat40), 1);
        clr = 1; cyc(); clr = 0;
        check_eq("sat_clr40", int'(sat40), 0);

        thresh = 1;
        det = 1; cyc();
        det = 0; repeat (6) cyc();
        clr = 1; cyc(); clr = 0;
        check_eq("clrc_done", int'(wd8), 0);
        check_eq("clrc_last", int'(lc8), 0);
        check_eq("clrc_alert", int'(al8), 0);
        thresh = 0;
        det = 1; cyc();
        det = 0;
        wait_done(10, "w5_done");
        check_eq("w5_last", int'(lc8), 1);
        det = 1; cyc();
        det = 0; repeat (2) cyc();
        en = 0; cyc();
        check_eq("endrop_wc", int'(wc8), 0);
        check_eq("endrop_last", int'(lc8), 1);
        en = 1;

        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(99) < 98);
            clr = ($urandom_range(99) < 2);
            det = $urandom_range(1);
            if ($urandom_range(19) == 0) thresh = 4'($urandom_range(15));
            cyc();
            if ($urandom_range(399) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
